fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 15 +
 rtl/wrap_ptr.sv | 19 +
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO control block.
// Defaults describe a 4-word, 8-bit FIFO.
package fifo_pkg;

  localparam int DEPTH_DEF    = 4;
  localparam int BITS_DEF     = 8;
  localparam int AF_LEVEL_DEF = 3;
  localparam int AE_LEVEL_DEF = 1;

  // Address width of the storage array; never below 1 bit.
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Free-running pointer with enable and synchronous active-low clear.
// The natural binary rollover provides the wrap bit.
module wrap_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!clr)
      ptr <= '0;
    else if (en)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Control-only FIFO: one-hot write enables, read select and occupancy flags.
// Storage registers and the read multiplexer live outside this block.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [DEPTH-1:0] wr_load,
  output logic [AW-1:0]    rd_sel,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;
  logic        unused_wrap;

  // A write into a full FIFO is accepted when a read frees the slot on the same edge.
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;

  wrap_ptr #(.W(AW+1)) u_wr_ptr (
    .clk (clk),
    .clr (clr),
    .en  (wr_ok),
    .ptr (wr_ptr)
  );

  wrap_ptr #(.W(AW+1)) u_rd_ptr (
    .clk (clk),
    .clr (clr),
    .en  (rd_ok),
    .ptr (rd_ptr)
  );

  // Wrap bits are kept for debug visibility; occupancy comes from count.
  assign unused_wrap = wr_ptr[AW] ^ rd_ptr[AW];

  // Held low during reset so no storage word is touched while occupancy is discarded.
  always_comb begin
    wr_load = '0;
    if (clr && wr_ok)
      wr_load[wr_ptr[AW-1:0]] = 1'b1;
  end

  assign rd_sel = rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (!clr) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok && !rd_ok)
        count <= count + 1'b1;
      else if (rd_ok && !wr_ok)
        count <= count - 1'b1;
      if (wr_en && full && !rd_en)
        ovf <= 1'b1;
      if (rd_en && empty)
        udf <= 1'b1;
    end
  end

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl (DEPTH=4, AF=3, AE=1) with an external word array.
// The reference model tracks stored words in a queue and slot positions by transfer totals.
module tb_fifo_ctrl;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [3:0] wr_load;
  logic [1:0] rd_sel;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, ovf, udf;

  logic [7:0] mem [DEPTH];

  typedef struct {
    logic [3:0] wr_load;
    logic [1:0] rd_sel;
    logic [2:0] count;
    logic       full, empty, af, ae, ovf, udf;
    bit         chk_load;
    bit         chk_data;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mq[$];
  int unsigned m_wr = 0;
  int unsigned m_rd = 0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  int          checks = 0;
  int          errors = 0;

  fifo_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .clr          (clr),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_load      (wr_load),
    .rd_sel       (rd_sel),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  // Storage that would sit beside the controller.
  always @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (wr_load[i]) mem[i] <= wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, record what the DUT must show now, then advance the model across the next edge.
  task automatic step(input logic c, input logic w, input logic r);
    exp_t e;
    int   n;
    bit   wa, ra;
    @(posedge clk);
    #1;
    clr   = c;
    wr_en = w;
    rd_en = r;
    wdata = 8'($urandom);
    n  = mq.size();
    wa = w && (n < DEPTH || r);
    ra = r && (n > 0);
    e.count    = 3'(n);
    e.full     = (n == DEPTH);
    e.empty    = (n == 0);
    e.af       = (n >= AF);
    e.ae       = (n <= AE);
    e.ovf      = m_ovf;
    e.udf      = m_udf;
    e.rd_sel   = 2'(m_rd % DEPTH);
    e.wr_load  = wa ? 4'(1 << (m_wr % DEPTH)) : 4'b0000;
    e.chk_load = c;
    e.chk_data = c && ra;
    e.data     = ra ? mq[0] : 8'h00;
    sb.push_back(e);
    if (!c) begin
      mq.delete();
      m_wr  = 0;
      m_rd  = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && n == DEPTH && !r) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
      if (ra) begin
        void'(mq.pop_front());
        m_rd++;
      end
      if (wa) begin
        mq.push_back(wdata);
        m_wr++;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count", 32'(count), 32'(e.count));
        chk("full", 32'(full), 32'(e.full));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("almost_full", 32'(almost_full), 32'(e.af));
        chk("almost_empty", 32'(almost_empty), 32'(e.ae));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("udf", 32'(udf), 32'(e.udf));
        chk("rd_sel", 32'(rd_sel), 32'(e.rd_sel));
        if (e.chk_load)
          chk("wr_load", 32'(wr_load), 32'(e.wr_load));
        if (e.chk_data)
          chk("rd_data", 32'(mem[rd_sel]), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
    end
    repeat (2) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      int wbias;
      wbias = (i / 100) % 3;
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) < 1 + wbias),
           ($urandom_range(0, 3) < 3 - wbias));
    end
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
